// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: round-robin arbiter that grants one requester a fixed-length burst of row writes to the register bank.
module regbank_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 16,
  parameter int ROW_W = 4,
  parameter logic [ROW_W-1:0] BASE_ROW = 4'b1000,
  parameter int BURST_LEN = 4,
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BW-1:0]             next_beat,
  output logic [ROW_W-1:0]          rowaddr,
  output logic [DATA_W-1:0]         wdata,
  output logic                      writemem,
  output logic [NUM_REQ-1:0]        done
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, owner, win, idx, src;
  logic [CW-1:0] beat, beat_inc;
  logic [BW-1:0] nb;
  logic [DATA_W-1:0] data;
  // Scan downward so the requester closest to rr_ptr is the last, winning assignment.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) win = idx;
    end
    src = (state == IDLE) ? win : owner;
    data = req_data[int'(src)*DATA_W +: DATA_W];
    beat_inc = beat + 1'b1;
    nb = (beat_inc == CW'(BURST_LEN)) ? '0 : BW'(beat_inc);
  end
  // State advances on the falling edge so the bank sees stable signals on the rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beat <= '0;
      grant <= '0;
      next_beat <= '0;
      rowaddr <= BASE_ROW;
      wdata <= '0;
      writemem <= 1'b0;
      done <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            owner <= win;
            grant <= NUM_REQ'(1) << win;
            writemem <= 1'b1;
            rowaddr <= BASE_ROW;
            wdata <= data;
            beat <= CW'(1);
            next_beat <= (BURST_LEN > 1) ? BW'(1) : '0;
            state <= (BURST_LEN == 1) ? DONE : BURST;
          end
        end
        BURST: begin
          rowaddr <= BASE_ROW + ROW_W'(beat);
          wdata <= data;
          next_beat <= nb;
          beat <= beat_inc;
          if (beat == CW'(BURST_LEN - 1)) state <= DONE;
        end
        DONE: begin
          writemem <= 1'b0;
          grant <= '0;
          rowaddr <= BASE_ROW;
          wdata <= '0;
          next_beat <= '0;
          done <= NUM_REQ'(1) << owner;
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
